// File: rtl/hv_memory_server_pkg.sv
// rtl/hv_memory_server_pkg.sv - shared constants, select encodings and FSM states for the HV memory server
package hv_memory_server_pkg;

  localparam int HV_DIMENSION   = 2000;
  localparam int SRAM_WIDTH_DEF = 40;
  localparam int SRAM_AW_DEF    = 17;
  localparam int WORDS_DEF      = HV_DIMENSION / SRAM_WIDTH_DEF;

  // Matrix selects: item memory, then positive and negative projection matrices per modality
  typedef enum logic [2:0] {
    SEL_IM         = 3'd0,
    SEL_PROJ_POS_1 = 3'd1,
    SEL_PROJ_POS_2 = 3'd2,
    SEL_PROJ_POS_3 = 3'd3,
    SEL_PROJ_NEG_1 = 3'd4,
    SEL_PROJ_NEG_2 = 3'd5,
    SEL_PROJ_NEG_3 = 3'd6,
    SEL_ILLEGAL    = 3'd7
  } hv_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_RESP
  } srv_state_e;

endpackage

// File: rtl/hv_sram_addr_gen.sv
// rtl/hv_sram_addr_gen.sv - SRAM word address from matrix select, row index and word counter
module hv_sram_addr_gen #(
  parameter int WORDS = 50,
  parameter int KW    = 6,
  parameter int AW    = 17
) (
  input  logic [2:0]    sel,
  input  logic [7:0]    row,
  input  logic [KW-1:0] k,
  output logic [AW-1:0] addr
);

  logic [AW-1:0] line;

  // Each (select, row) pair owns WORDS consecutive words; arithmetic stays unsigned at AW bits
  always_comb begin
    line = AW'({sel, row});
    addr = line * AW'(WORDS) + AW'(k);
  end

endmodule

// File: rtl/hv_memory_server.sv
// rtl/hv_memory_server.sv - serves whole hypervectors by streaming SRAM words into an assembly buffer
module hv_memory_server
  import hv_memory_server_pkg::*;
#(
  parameter int HV_DIM     = HV_DIMENSION,
  parameter int SRAM_WIDTH = SRAM_WIDTH_DEF,
  parameter int SRAM_AW    = SRAM_AW_DEF
) (
  input  logic                  Clk_CI,
  input  logic                  Reset_RI,
  input  logic                  ReqValid_SI,
  output logic                  ReqReady_SO,
  input  logic [7:0]            ReqAddr_DI,
  input  logic [2:0]            ReqSel_DI,
  output logic                  RespValid_SO,
  input  logic                  RespReady_SI,
  output logic [0:HV_DIM-1]     RespHV_DO,
  output logic                  RespErr_SO,
  output logic                  SramEn_SO,
  output logic [SRAM_AW-1:0]    SramAddr_SO,
  input  logic [SRAM_WIDTH-1:0] SramRdata_DI
);

  localparam int WORDS = HV_DIM / SRAM_WIDTH;
  localparam int KW    = $clog2(WORDS);

  srv_state_e         state_q, state_d;
  logic [KW-1:0]      k_q;
  logic [7:0]         row_q;
  logic [2:0]         sel_q;
  logic               rd_pend_q;
  logic [KW-1:0]      rd_idx_q;
  logic [0:HV_DIM-1]  hv_q;
  logic               err_q;
  logic [SRAM_AW-1:0] addr_hold_q;
  logic [SRAM_AW-1:0] gen_addr;
  logic               accept;
  logic               reading;

  assign accept  = ReqValid_SI && (state_q == ST_IDLE);
  assign reading = (state_q == ST_READ);

  hv_sram_addr_gen #(
    .WORDS (WORDS),
    .KW    (KW),
    .AW    (SRAM_AW)
  ) u_addr_gen (
    .sel  (sel_q),
    .row  (row_q),
    .k    (k_q),
    .addr (gen_addr)
  );

  // Next-state: illegal selects skip the SRAM entirely and answer at once
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (ReqSel_DI == SEL_ILLEGAL) ? ST_RESP : ST_READ;
      ST_READ:  if (k_q == KW'(WORDS - 1)) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_RESP;
      ST_RESP:  if (RespReady_SI) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Request capture and word counter
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      row_q <= '0;
      sel_q <= '0;
      k_q   <= '0;
    end else if (accept) begin
      row_q <= ReqAddr_DI;
      sel_q <= ReqSel_DI;
      k_q   <= '0;
    end else if (reading) begin
      k_q <= (k_q == KW'(WORDS - 1)) ? '0 : k_q + KW'(1);
    end
  end

  // Track which word returns next cycle; reset drops anything still in flight
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
      addr_hold_q <= '0;
    end else begin
      rd_pend_q <= reading;
      rd_idx_q  <= k_q;
      if (reading) addr_hold_q <= gen_addr;
    end
  end

  // Assembly buffer: word k lands MSB-first at HV index k*SRAM_WIDTH
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      hv_q  <= '0;
      err_q <= 1'b0;
    end else if (accept && (ReqSel_DI == SEL_ILLEGAL)) begin
      hv_q  <= '0;
      err_q <= 1'b1;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (rd_pend_q) begin
      hv_q[int'(rd_idx_q) * SRAM_WIDTH +: SRAM_WIDTH] <= SramRdata_DI;
    end
  end

  assign ReqReady_SO  = (state_q == ST_IDLE);
  assign RespValid_SO = (state_q == ST_RESP);
  assign RespHV_DO    = hv_q;
  assign RespErr_SO   = err_q;
  assign SramEn_SO    = reading;
  assign SramAddr_SO  = reading ? gen_addr : addr_hold_q;

endmodule

// File: tb/tb_hv_memory_server.sv
// tb/tb_hv_memory_server.sv - directed self-checking bench for hv_memory_server
module tb_hv_memory_server;

  localparam int DIM   = 2000;
  localparam int SW    = 40;
  localparam int AW    = 17;
  localparam int WORDS = DIM / SW;

  logic            Clk_CI = 1'b0;
  logic            Reset_RI;
  logic            ReqValid_SI;
  logic            ReqReady_SO;
  logic [7:0]      ReqAddr_DI;
  logic [2:0]      ReqSel_DI;
  logic            RespValid_SO;
  logic            RespReady_SI;
  logic [0:DIM-1]  RespHV_DO;
  logic            RespErr_SO;
  logic            SramEn_SO;
  logic [AW-1:0]   SramAddr_SO;
  logic [SW-1:0]   SramRdata_DI;

  int vectors = 0;
  int errors  = 0;

  int en_first, en_last, en_count, valid_cyc;
  logic [AW-1:0] addr_log [0:63];

  hv_memory_server #(
    .HV_DIM     (DIM),
    .SRAM_WIDTH (SW),
    .SRAM_AW    (AW)
  ) dut (
    .Clk_CI       (Clk_CI),
    .Reset_RI     (Reset_RI),
    .ReqValid_SI  (ReqValid_SI),
    .ReqReady_SO  (ReqReady_SO),
    .ReqAddr_DI   (ReqAddr_DI),
    .ReqSel_DI    (ReqSel_DI),
    .RespValid_SO (RespValid_SO),
    .RespReady_SI (RespReady_SI),
    .RespHV_DO    (RespHV_DO),
    .RespErr_SO   (RespErr_SO),
    .SramEn_SO    (SramEn_SO),
    .SramAddr_SO  (SramAddr_SO),
    .SramRdata_DI (SramRdata_DI)
  );

  initial forever #5 Clk_CI = ~Clk_CI;

  // SRAM model: one-cycle read latency, data equals the word address; junk when not enabled
  always @(posedge Clk_CI)
    SramRdata_DI <= SramEn_SO ? {{(SW-AW){1'b0}}, SramAddr_SO} : 40'hBAD0BAD0BA;

  task automatic step();
    @(posedge Clk_CI);
    #1;
  endtask

  function automatic logic [SW-1:0] slice(input int k);
    return RespHV_DO[k*SW +: SW];
  endfunction

  function automatic logic [AW-1:0] base_addr(input int sel, input int row);
    return AW'((sel * 256 + row) * WORDS);
  endfunction

  // Issue one request and record SRAM activity until the response appears (bounded)
  task automatic trace(input logic [2:0] sel, input logic [7:0] row);
    ReqSel_DI   = sel;
    ReqAddr_DI  = row;
    ReqValid_SI = 1'b1;
    step();
    ReqValid_SI = 1'b0;
    en_first = -1; en_last = -1; en_count = 0; valid_cyc = -1;
    for (int i = 1; i <= 120; i++) begin
      if (SramEn_SO) begin
        if (en_first < 0) en_first = i;
        en_last = i;
        if (en_count < 64) addr_log[en_count] = SramAddr_SO;
        en_count++;
      end
      if (RespValid_SO) begin
        valid_cyc = i;
        break;
      end
      step();
    end
  endtask

  task automatic handshake();
    RespReady_SI = 1'b1;
    step();
    RespReady_SI = 1'b0;
  endtask

  task automatic test_reset();
    Reset_RI = 1'b1; ReqValid_SI = 1'b0; ReqAddr_DI = '0; ReqSel_DI = '0; RespReady_SI = 1'b0;
    step(); step();
    vectors++; if (RespValid_SO !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", RespValid_SO); end
    vectors++; if (RespErr_SO !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", RespErr_SO); end
    vectors++; if (SramEn_SO !== 1'b0) begin errors++; $display("FAIL reset_en got %0b want 0", SramEn_SO); end
    vectors++; if (SramAddr_SO !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", SramAddr_SO); end
    vectors++; if (RespHV_DO !== '0) begin errors++; $display("FAIL reset_hv got nonzero want 0"); end
    Reset_RI = 1'b0;
    step();
    vectors++; if (ReqReady_SO !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", ReqReady_SO); end
  endtask

  task automatic test_im_row0();
    int bad_addr = 0, bad_slice = 0;
    trace(3'd0, 8'd0);
    vectors++; if (en_first != 1) begin errors++; $display("FAIL im_en_first got %0d want 1", en_first); end
    vectors++; if (en_last != WORDS) begin errors++; $display("FAIL im_en_last got %0d want %0d", en_last, WORDS); end
    vectors++; if (en_count != WORDS) begin errors++; $display("FAIL im_en_count got %0d want %0d", en_count, WORDS); end
    vectors++; if (valid_cyc != WORDS + 2) begin errors++; $display("FAIL im_latency got %0d want %0d", valid_cyc, WORDS + 2); end
    for (int k = 0; k < WORDS; k++) begin
      if (addr_log[k] !== AW'(k)) bad_addr++;
      if (slice(k) !== SW'(k)) bad_slice++;
    end
    vectors++; if (bad_addr != 0) begin errors++; $display("FAIL im_addr_seq got %0d bad want 0", bad_addr); end
    vectors++; if (bad_slice != 0) begin errors++; $display("FAIL im_slices got %0d bad want 0", bad_slice); end
    vectors++; if (RespErr_SO !== 1'b0) begin errors++; $display("FAIL im_err got %0b want 0", RespErr_SO); end
    handshake();
    vectors++; if (RespValid_SO !== 1'b0) begin errors++; $display("FAIL im_after_hs_valid got %0b want 0", RespValid_SO); end
    vectors++; if (ReqReady_SO !== 1'b1) begin errors++; $display("FAIL im_after_hs_ready got %0b want 1", ReqReady_SO); end
  endtask

  task automatic test_max_addr();
    trace(3'd6, 8'd255);
    vectors++; if (addr_log[0] !== AW'(89550)) begin errors++; $display("FAIL max_first_addr got %0d want 89550", addr_log[0]); end
    vectors++; if (addr_log[WORDS-1] !== AW'(89599)) begin errors++; $display("FAIL max_last_addr got %0d want 89599", addr_log[WORDS-1]); end
    vectors++; if (RespErr_SO !== 1'b0) begin errors++; $display("FAIL max_err got %0b want 0", RespErr_SO); end
    vectors++; if (slice(0) !== SW'(89550)) begin errors++; $display("FAIL max_slice0 got %0d want 89550", slice(0)); end
    vectors++; if (slice(WORDS-1) !== SW'(89599)) begin errors++; $display("FAIL max_slice49 got %0d want 89599", slice(WORDS-1)); end
    handshake();
  endtask

  task automatic test_illegal();
    trace(3'd7, 8'd3);
    vectors++; if (en_count != 0) begin errors++; $display("FAIL ill_en_count got %0d want 0", en_count); end
    vectors++; if (valid_cyc != 1) begin errors++; $display("FAIL ill_latency got %0d want 1", valid_cyc); end
    vectors++; if (RespHV_DO !== '0) begin errors++; $display("FAIL ill_hv got nonzero want 0"); end
    vectors++; if (RespErr_SO !== 1'b1) begin errors++; $display("FAIL ill_err got %0b want 1", RespErr_SO); end
    handshake();
  endtask

  task automatic test_stall();
    logic [0:DIM-1] snap;
    int bad = 0;
    int got = 0;
    trace(3'd3, 8'd5);
    snap = RespHV_DO;
    vectors++; if (slice(0) !== SW'(base_addr(3, 5))) begin errors++; $display("FAIL stall_slice0 got %0d want %0d", slice(0), base_addr(3, 5)); end
    vectors++; if (RespErr_SO !== 1'b0) begin errors++; $display("FAIL stall_err_cleared got %0b want 0", RespErr_SO); end
    ReqSel_DI = 3'd1; ReqAddr_DI = 8'd2; ReqValid_SI = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (RespValid_SO !== 1'b1 || RespHV_DO !== snap || ReqReady_SO !== 1'b0 || SramEn_SO !== 1'b0) bad++;
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
    handshake();
    vectors++; if (ReqReady_SO !== 1'b1 || SramEn_SO !== 1'b0) begin errors++; $display("FAIL stall_idle got ready=%0b en=%0b want ready=1 en=0", ReqReady_SO, SramEn_SO); end
    step();
    ReqValid_SI = 1'b0;
    vectors++; if (SramEn_SO !== 1'b1 || SramAddr_SO !== base_addr(1, 2)) begin errors++; $display("FAIL stall_accept got en=%0b addr=%0d want en=1 addr=%0d", SramEn_SO, SramAddr_SO, base_addr(1, 2)); end
    for (int i = 0; i < 100; i++) begin
      if (RespValid_SO) begin got = 1; break; end
      step();
    end
    vectors++; if (got != 1 || slice(WORDS-1) !== SW'(base_addr(1, 2) + AW'(WORDS-1))) begin errors++; $display("FAIL stall_second_resp got valid=%0d slice49=%0d want 1 %0d", got, slice(WORDS-1), base_addr(1, 2) + AW'(WORDS-1)); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    ReqSel_DI = 3'd2; ReqAddr_DI = 8'd0; ReqValid_SI = 1'b1;
    step();
    ReqValid_SI = 1'b0;
    for (int i = 0; i < 25; i++) step();
    vectors++; if (SramEn_SO !== 1'b1 || SramAddr_SO !== AW'(25625)) begin errors++; $display("FAIL mid_k25 got en=%0b addr=%0d want en=1 addr=25625", SramEn_SO, SramAddr_SO); end
    #2 Reset_RI = 1'b1;
    #1;
    vectors++; if (SramEn_SO !== 1'b0 || SramAddr_SO !== '0) begin errors++; $display("FAIL mid_async got en=%0b addr=%0d want en=0 addr=0", SramEn_SO, SramAddr_SO); end
    step();
    Reset_RI = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (RespValid_SO !== 1'b0) bad++;
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL mid_no_resp got %0d valid cycles want 0", bad); end
    trace(3'd1, 8'd1);
    vectors++; if (addr_log[0] !== AW'(12850)) begin errors++; $display("FAIL mid_first_addr got %0d want 12850", addr_log[0]); end
    vectors++; if (valid_cyc != WORDS + 2) begin errors++; $display("FAIL mid_latency got %0d want %0d", valid_cyc, WORDS + 2); end
    vectors++; if (slice(0) !== SW'(12850) || slice(WORDS-1) !== SW'(12899)) begin errors++; $display("FAIL mid_slices got %0d %0d want 12850 12899", slice(0), slice(WORDS-1)); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int cyc = -1;
    logic [SW-1:0] s0, s49;
    ReqSel_DI = 3'd2; ReqAddr_DI = 8'd10; ReqValid_SI = 1'b1; RespReady_SI = 1'b1;
    step();
    ReqSel_DI = 3'd4;
    for (int i = 1; i <= 100; i++) begin
      if (RespValid_SO) begin cyc = i; break; end
      step();
    end
    s0 = slice(0); s49 = slice(WORDS-1);
    vectors++; if (cyc != WORDS + 2) begin errors++; $display("FAIL b2b_first_latency got %0d want %0d", cyc, WORDS + 2); end
    vectors++; if (s0 !== SW'(26100) || s49 !== SW'(26149)) begin errors++; $display("FAIL b2b_first_hv got %0d %0d want 26100 26149", s0, s49); end
    step();
    vectors++; if (ReqReady_SO !== 1'b1 || SramEn_SO !== 1'b0) begin errors++; $display("FAIL b2b_gap got ready=%0b en=%0b want 1 0", ReqReady_SO, SramEn_SO); end
    step();
    ReqValid_SI = 1'b0;
    vectors++; if (SramEn_SO !== 1'b1 || SramAddr_SO !== AW'(51700)) begin errors++; $display("FAIL b2b_second_accept got en=%0b addr=%0d want 1 51700", SramEn_SO, SramAddr_SO); end
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      if (RespValid_SO) begin cyc = i; break; end
      step();
    end
    vectors++; if (cyc < 0 || slice(0) !== SW'(51700) || slice(WORDS-1) !== SW'(51749)) begin errors++; $display("FAIL b2b_second_hv got cyc=%0d %0d %0d want 51700 51749", cyc, slice(0), slice(WORDS-1)); end
    vectors++; if (RespErr_SO !== 1'b0) begin errors++; $display("FAIL b2b_err got %0b want 0", RespErr_SO); end
    step();
    RespReady_SI = 1'b0;
    vectors++; if (RespValid_SO !== 1'b0) begin errors++; $display("FAIL b2b_done got %0b want 0", RespValid_SO); end
  endtask

  initial begin
    test_reset();
    test_im_row0();
    test_max_addr();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
